// File: rtl/geriyaz_birimi.sv
// ============================================================================
//  Module   : geriyaz_birimi
//  Brief    : Writeback stage. Merges memory-stage results and long-latency
//             (mul/div) results into one registered writeback per cycle on
//             the geriyaz_* bus. Long results wait in a 2-entry FIFO; memory
//             results win unless that FIFO is full. Results to x0 are
//             accepted and discarded.
//  Option   : GERIYAZ_SAYAC_EN - adds a 64-bit writeback counter on
//             geriyaz_sayac_o.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef VERI_BIT
`define VERI_BIT 32
`endif
`ifndef YAZMAC_BIT
`define YAZMAC_BIT 5
`endif
`ifndef UOP_TAG_BIT
`define UOP_TAG_BIT 6
`endif

module geriyaz_birimi (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [`VERI_BIT-1:0]    bellek_veri_i,
  input  logic [`YAZMAC_BIT-1:0]  bellek_adres_i,
  input  logic [`UOP_TAG_BIT-1:0] bellek_etiket_i,
  input  logic                    bellek_gecerli_i,
  output logic                    bellek_hazir_o,
  input  logic [`VERI_BIT-1:0]    uzun_veri_i,
  input  logic [`YAZMAC_BIT-1:0]  uzun_adres_i,
  input  logic [`UOP_TAG_BIT-1:0] uzun_etiket_i,
  input  logic                    uzun_gecerli_i,
  output logic                    uzun_hazir_o,
  output logic [`VERI_BIT-1:0]    geriyaz_veri_o,
  output logic [`YAZMAC_BIT-1:0]  geriyaz_adres_o,
  output logic [`UOP_TAG_BIT-1:0] geriyaz_etiket_o,
  output logic                    geriyaz_gecerli_o
`ifdef GERIYAZ_SAYAC_EN
  ,output logic [63:0]            geriyaz_sayac_o
`endif
);

  localparam int c_VB = `VERI_BIT;
  localparam int c_AB = `YAZMAC_BIT;
  localparam int c_TB = `UOP_TAG_BIT;
  localparam int c_EW = c_VB + c_AB + c_TB;

  // FIFO storage: entry = {data, address, tag}
  logic [c_EW-1:0] r_fifo [2];
  logic            r_wr;
  logic            r_rd;
  logic [1:0]      r_cnt;

  logic [c_EW-1:0] r_out;
  logic            r_out_valid;

  logic            w_full;
  logic            w_empty;
  logic            w_mem_keep;
  logic            w_long_keep;
  logic            w_push;
  logic            w_pop;
  logic            w_sel_valid;
  logic [c_EW-1:0] w_sel;
  logic [c_EW-1:0] w_mem_ent;
  logic [c_EW-1:0] w_long_ent;

  // Handshakes depend only on the registered count, so no input reaches an output combinationally.
  assign w_full         = (r_cnt == 2'd2);
  assign w_empty        = (r_cnt == 2'd0);
  assign bellek_hazir_o = ~w_full;
  assign uzun_hazir_o   = ~w_full;

  assign w_mem_ent  = {bellek_veri_i, bellek_adres_i, bellek_etiket_i};
  assign w_long_ent = {uzun_veri_i, uzun_adres_i, uzun_etiket_i};

  // Accepted results headed for x0 are swallowed here: they never compete for the output or the FIFO.
  assign w_mem_keep  = bellek_gecerli_i & ~w_full & (bellek_adres_i != '0);
  assign w_long_keep = uzun_gecerli_i   & ~w_full & (uzun_adres_i   != '0);

  // Output selection in priority order: full FIFO drain, memory, FIFO head, long bypass.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel       = '0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    if (w_full) begin
      w_sel_valid = 1'b1;
      w_sel       = r_fifo[r_rd];
      w_pop       = 1'b1;
    end else if (w_mem_keep) begin
      w_sel_valid = 1'b1;
      w_sel       = w_mem_ent;
      w_push      = w_long_keep;
    end else if (!w_empty) begin
      w_sel_valid = 1'b1;
      w_sel       = r_fifo[r_rd];
      w_pop       = 1'b1;
      w_push      = w_long_keep;
    end else if (w_long_keep) begin
      w_sel_valid = 1'b1;
      w_sel       = w_long_ent;
    end
  end

  // FIFO pointers, count and storage; reset throws away anything buffered.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
      r_cnt     <= 2'd0;
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr] <= w_long_ent;
        r_wr         <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Registered writeback bus; valid is recomputed every cycle so each writeback lasts one cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out       <= w_sel;
      r_out_valid <= w_sel_valid;
    end
  end

  assign geriyaz_veri_o    = r_out[c_EW-1 -: c_VB];
  assign geriyaz_adres_o   = r_out[c_TB +: c_AB];
  assign geriyaz_etiket_o  = r_out[c_TB-1:0];
  assign geriyaz_gecerli_o = r_out_valid;

`ifdef GERIYAZ_SAYAC_EN
  logic [63:0] r_sayac;

  // Counts cycles whose next-cycle writeback is valid; wraps naturally at 2^64.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sayac <= 64'd0;
    end else if (w_sel_valid) begin
      r_sayac <= r_sayac + 64'd1;
    end
  end

  assign geriyaz_sayac_o = r_sayac;
`endif

endmodule

`default_nettype wire

// File: tb/tb_geriyaz_birimi.sv
// ============================================================================
//  Module   : tb_geriyaz_birimi
//  Brief    : Scoreboard bench for geriyaz_birimi. Directed stimulus pushes
//             hand-computed writebacks into a queue in expected output order;
//             a monitor pops and compares on every valid writeback.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef VERI_BIT
`define VERI_BIT 32
`endif
`ifndef YAZMAC_BIT
`define YAZMAC_BIT 5
`endif
`ifndef UOP_TAG_BIT
`define UOP_TAG_BIT 6
`endif

module tb_geriyaz_birimi;

  typedef struct packed {
    logic [`VERI_BIT-1:0]    d;
    logic [`YAZMAC_BIT-1:0]  a;
    logic [`UOP_TAG_BIT-1:0] t;
  } wb_t;

  logic                    clk = 1'b0;
  logic                    rstn = 1'b0;
  logic [`VERI_BIT-1:0]    m_d = '0;
  logic [`YAZMAC_BIT-1:0]  m_a = '0;
  logic [`UOP_TAG_BIT-1:0] m_t = '0;
  logic                    m_v = 1'b0;
  logic                    m_rdy;
  logic [`VERI_BIT-1:0]    l_d = '0;
  logic [`YAZMAC_BIT-1:0]  l_a = '0;
  logic [`UOP_TAG_BIT-1:0] l_t = '0;
  logic                    l_v = 1'b0;
  logic                    l_rdy;
  logic [`VERI_BIT-1:0]    g_d;
  logic [`YAZMAC_BIT-1:0]  g_a;
  logic [`UOP_TAG_BIT-1:0] g_t;
  logic                    g_v;
`ifdef GERIYAZ_SAYAC_EN
  logic [63:0]             g_cnt;
`endif

  int  checks   = 0;
  int  failures = 0;
  wb_t exp_q[$];

  geriyaz_birimi dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .bellek_veri_i    (m_d),
    .bellek_adres_i   (m_a),
    .bellek_etiket_i  (m_t),
    .bellek_gecerli_i (m_v),
    .bellek_hazir_o   (m_rdy),
    .uzun_veri_i      (l_d),
    .uzun_adres_i     (l_a),
    .uzun_etiket_i    (l_t),
    .uzun_gecerli_i   (l_v),
    .uzun_hazir_o     (l_rdy),
    .geriyaz_veri_o   (g_d),
    .geriyaz_adres_o  (g_a),
    .geriyaz_etiket_o (g_t),
    .geriyaz_gecerli_o(g_v)
`ifdef GERIYAZ_SAYAC_EN
    ,.geriyaz_sayac_o (g_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_wb(input logic [31:0] d, input logic [4:0] a, input logic [5:0] t);
    wb_t e;
    e.d = d[`VERI_BIT-1:0];
    e.a = a[`YAZMAC_BIT-1:0];
    e.t = t[`UOP_TAG_BIT-1:0];
    exp_q.push_back(e);
  endtask

  // Apply one cycle of inputs (called at posedge+2), wait past the edge, then drop the valids.
  task automatic cyc(input logic mv, input logic [4:0] ma, input logic [31:0] md, input logic [5:0] mt,
                     input logic lv, input logic [4:0] la, input logic [31:0] ld, input logic [5:0] lt);
    m_v = mv; m_a = ma[`YAZMAC_BIT-1:0]; m_d = md[`VERI_BIT-1:0]; m_t = mt[`UOP_TAG_BIT-1:0];
    l_v = lv; l_a = la[`YAZMAC_BIT-1:0]; l_d = ld[`VERI_BIT-1:0]; l_t = lt[`UOP_TAG_BIT-1:0];
    @(posedge clk);
    #2;
    m_v = 1'b0;
    l_v = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every valid writeback must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && g_v) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_wb actual=x%0d/%0h/t%0h required=none", g_a, g_d, g_t);
        end else begin
          wb_t e;
          e = exp_q.pop_front();
          chk("wb_data", 64'(g_d), 64'(e.d));
          chk("wb_addr", 64'(g_a), 64'(e.a));
          chk("wb_tag",  64'(g_t), 64'(e.t));
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", 64'(g_v), 0);
    chk("rst_data",  64'(g_d), 0);
    chk("rst_mrdy",  64'(m_rdy), 1);
    chk("rst_lrdy",  64'(l_rdy), 1);
    rstn = 1'b1;
    idle(1);

    // Memory passthrough, then idle: any extra valid cycle is flagged by the monitor.
    expect_wb(32'hDEADBEEF, 5, 3);
    cyc(1, 5, 32'hDEADBEEF, 3, 0, 0, 0, 0);
    idle(2);

    // Simultaneous sources: memory first, buffered long result next cycle.
    expect_wb(32'h11, 1, 1);
    expect_wb(32'h22, 2, 2);
    cyc(1, 1, 32'h11, 1, 1, 2, 32'h22, 2);
    chk("sim_lrdy_cnt1", 64'(l_rdy), 1);
    idle(2);
    chk("sim_lrdy_cnt0", 64'(l_rdy), 1);

    // FIFO full: M0 L0 M0' ... order M0,M1,L0,M2(held),M3,L1.
    expect_wb(32'hA0, 3, 4);
    expect_wb(32'hA1, 4, 5);
    expect_wb(32'hB0, 8, 8);
    expect_wb(32'hA2, 6, 6);
    expect_wb(32'hA3, 7, 7);
    expect_wb(32'hB1, 9, 9);
    cyc(1, 3, 32'hA0, 4, 1, 8, 32'hB0, 8);
    cyc(1, 4, 32'hA1, 5, 1, 9, 32'hB1, 9);
    chk("full_mrdy", 64'(m_rdy), 0);
    chk("full_lrdy", 64'(l_rdy), 0);
    cyc(1, 6, 32'hA2, 6, 0, 0, 0, 0);   // not accepted, memory holds
    chk("drain_mrdy", 64'(m_rdy), 1);
    cyc(1, 6, 32'hA2, 6, 0, 0, 0, 0);
    cyc(1, 7, 32'hA3, 7, 0, 0, 0, 0);
    idle(1);
    chk("empty_lrdy", 64'(l_rdy), 1);
    idle(2);

    // x0 drops: accepted, nothing written, count stays 0.
    chk("x0_lrdy_pre", 64'(l_rdy), 1);
    cyc(0, 0, 0, 0, 1, 0, 32'h55, 1);
    chk("x0_lrdy_post", 64'(l_rdy), 1);
    cyc(1, 0, 32'h66, 2, 0, 0, 0, 0);
    chk("x0_mrdy_post", 64'(m_rdy), 1);
    idle(2);

    // Long bypass with empty FIFO: one-cycle latency.
    expect_wb(32'h77, 10, 10);
    cyc(0, 0, 0, 0, 1, 10, 32'h77, 10);
    idle(2);

    // Asynchronous reset with the FIFO full.
    expect_wb(32'hC0, 11, 11);
    expect_wb(32'hC1, 12, 12);
    cyc(1, 11, 32'hC0, 11, 1, 13, 32'hD0, 13);
    cyc(1, 12, 32'hC1, 12, 1, 14, 32'hD1, 14);
    chk("prerst_lrdy", 64'(l_rdy), 0);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid", 64'(g_v), 0);
    chk("arst_data",  64'(g_d), 0);
    chk("arst_addr",  64'(g_a), 0);
    chk("arst_tag",   64'(g_t), 0);
    chk("arst_mrdy",  64'(m_rdy), 1);
    chk("arst_lrdy",  64'(l_rdy), 1);
    @(posedge clk);
    #2;
    rstn = 1'b1;
    idle(4);
    chk("postrst_lrdy", 64'(l_rdy), 1);

`ifdef GERIYAZ_SAYAC_EN
    // Counter: 10 writebacks plus 3 x0 drops after a fresh reset.
    rstn = 1'b0;
    #1;
    chk("cnt_rst", g_cnt, 0);
    @(posedge clk);
    #2;
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      expect_wb(32'h100 + i, 5'(i + 1), 6'(i));
      cyc(1, 5'(i + 1), 32'h100 + i, 6'(i), 0, 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, 32'h9, 1);
    idle(2);
    chk("cnt_final", g_cnt, 10);
`endif

    idle(2);
    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
